// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply or restoring divide,
// fixed latency, one-cycle write-back straight into the register file port.
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic                     kill,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    result,
    output logic [ADDRESS_WIDTH-1:0] wb_addr,
    output logic                     wb_en
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

    state_e                   state_q;
    logic [2:0]               funct3_q;
    logic [W-1:0]             a_q, b_q;
    logic [2*W-1:0]           acc_q;
    logic [CW-1:0]            cnt_q;
    logic                     neg_q, busy_q, done_q, wb_en_q;
    logic [W-1:0]             result_q;
    logic [ADDRESS_WIDTH-1:0] wb_addr_q;

    logic                     is_div;
    logic                     a_neg, b_neg, neg_d;
    logic [W-1:0]             a_mag, b_mag;
    logic [W:0]               mul_sum, div_top, div_diff;
    logic [2*W-1:0]           mul_next, div_next, acc_neg;
    logic [W-1:0]             rem_neg, fix_val;

    assign is_div = funct3_q[2];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        neg_d = 1'b0;
        case (funct3_q)
            3'd1, 3'd4, 3'd6: begin
                a_neg = a_q[W-1];
                b_neg = b_q[W-1];
            end
            3'd2:    a_neg = a_q[W-1];
            default: ;
        endcase
        case (funct3_q)
            3'd1:       neg_d = a_neg ^ b_neg;
            3'd2, 3'd6: neg_d = a_neg;
            // A zero divisor yields all-ones regardless of the dividend sign.
            3'd4:       neg_d = (a_neg ^ b_neg) & (|b_q);
            default:    neg_d = 1'b0;
        endcase
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
    end

    // Multiply keeps the multiplier in the low half; the carry rides in the shift.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

    // Divide: shifted partial remainder needs W+1 bits when the divisor is large.
    assign div_top  = acc_q[2*W-1:W-1];
    assign div_diff = div_top - {1'b0, b_q};
    assign div_next = div_diff[W] ? {div_top[W-1:0], acc_q[W-2:0], 1'b0}
                                  : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

    assign acc_neg = -acc_q;
    assign rem_neg = -acc_q[2*W-1:W];

    always_comb begin
        fix_val = acc_q[W-1:0];
        case (funct3_q)
            3'd0:             fix_val = acc_q[W-1:0];
            3'd1, 3'd2, 3'd3: fix_val = neg_q ? acc_neg[2*W-1:W] : acc_q[2*W-1:W];
            3'd4, 3'd5:       fix_val = neg_q ? acc_neg[W-1:0]   : acc_q[W-1:0];
            default:          fix_val = neg_q ? rem_neg          : acc_q[2*W-1:W];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            funct3_q  <= 3'd0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            result_q  <= '0;
            wb_addr_q <= '0;
        end else begin
            done_q  <= 1'b0;
            wb_en_q <= 1'b0;
            if (kill && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // The done cycle still counts as busy, so a start there is dropped.
                        if (done_q) begin
                            busy_q <= 1'b0;
                        end else if (start) begin
                            funct3_q  <= funct3;
                            a_q       <= op_a;
                            b_q       <= op_b;
                            wb_addr_q <= rd_addr;
                            busy_q    <= 1'b1;
                            state_q   <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        a_q     <= a_mag;
                        b_q     <= b_mag;
                        neg_q   <= neg_d;
                        acc_q   <= {{W{1'b0}}, a_mag};
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end
                    S_RUN: begin
                        acc_q <= is_div ? div_next : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(W - 1)) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        result_q <= fix_val;
                        done_q   <= 1'b1;
                        wb_en_q  <= |wb_addr_q;
                        state_q  <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign wb_addr = wb_addr_q;
    assign wb_en   = wb_en_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, corners, control.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_addr;
    logic        kill;
    logic        busy, done, wb_en;
    logic [31:0] result;
    logic [4:0]  wb_addr;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_addr (rd_addr),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wb_addr (wb_addr),
        .wb_en   (wb_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Entered and left 1 time unit after a rising edge with the unit idle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int restart_at = 0, input int kill_at = 0, input int rst_at = 0);
        int  k       = 0;
        int  not_busy = 0;
        int  dones   = 0;
        bit  got     = 1'b0;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_addr = rd;
        @(posedge clk); #1;
        start = 1'b0; funct3 = ~f; op_a = ~a; op_b = b + 32'd1; rd_addr = ~rd;
        check({tag, " busy_at_accept"}, {31'd0, busy}, 32'd1);
        while (k < 40 && !got) begin
            k++;
            if (k == restart_at) start = 1'b1;
            if (k == kill_at)    kill  = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            kill  = 1'b0;
            if (k == kill_at) begin
                check({tag, " busy_after_kill"}, {31'd0, busy}, 32'd0);
                for (int j = 0; j < 40; j++) begin
                    @(posedge clk); #1;
                    if (done || wb_en) dones++;
                end
                check({tag, " no_done_after_kill"}, dones, 0);
                return;
            end
            if (k == rst_at) begin
                #3 rst_n = 1'b0;
                #1;
                check({tag, " rst_busy"},    {31'd0, busy},  32'd0);
                check({tag, " rst_done"},    {31'd0, done},  32'd0);
                check({tag, " rst_result"},  result,          32'd0);
                check({tag, " rst_wb_addr"}, {27'd0, wb_addr}, 32'd0);
                check({tag, " rst_wb_en"},   {31'd0, wb_en}, 32'd0);
                @(posedge clk);
                @(negedge clk) rst_n = 1'b1;
                for (int j = 0; j < 40; j++) begin
                    @(posedge clk); #1;
                    if (done || busy) dones++;
                end
                check({tag, " quiet_after_rst"}, dones, 0);
                return;
            end
            if (done) got = 1'b1;
            else if (!busy) not_busy++;
        end
        check({tag, " latency"},  k, 34);
        check({tag, " busy_gap"}, not_busy, 0);
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd1);
        check({tag, " result"},   result, exp);
        check({tag, " wb_addr"},  {27'd0, wb_addr}, {27'd0, rd});
        check({tag, " wb_en"},    {31'd0, wb_en}, {31'd0, rd != 5'd0});
        // A start presented during the done cycle must be dropped.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_clear"}, {31'd0, done},  32'd0);
        check({tag, " wb_en_clear"}, {31'd0, wb_en}, 32'd0);
        check({tag, " idle_busy"},  {31'd0, busy},  32'd0);
        check({tag, " result_hold"}, result, exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0;
        funct3 = 3'd0; op_a = '0; op_b = '0; rd_addr = '0;
        #12;
        check("reset busy",    {31'd0, busy},    32'd0);
        check("reset done",    {31'd0, done},    32'd0);
        check("reset result",  result,           32'd0);
        check("reset wb_addr", {27'd0, wb_addr}, 32'd0);
        check("reset wb_en",   {31'd0, wb_en},   32'd0);
        @(negedge clk) rst_n = 1'b1;
        // kill while idle must not disturb anything
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("idle kill busy", {31'd0, busy}, 32'd0);

        run_op("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
        run_op("mulh",    3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000);
        run_op("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE);
        run_op("mulhsu",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF);
        run_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD);
        run_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF);
        run_op("divu",    3'd5, 32'd100,      32'd7,        5'd11, 32'd14);
        run_op("remu",    3'd7, 32'd100,      32'd7,        5'd12, 32'd2);
        run_op("divu0",   3'd5, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF);
        run_op("remu0",   3'd7, 32'd5,        32'd0,        5'd14, 32'd5);
        run_op("div0neg", 3'd4, 32'hFFFFFFF9, 32'd0,        5'd15, 32'hFFFFFFFF);
        run_op("rem0neg", 3'd6, 32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFF9);
        run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000);
        run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0);
        run_op("restart", 3'd5, 32'd100,      32'd7,        5'd19, 32'd14, 10);
        run_op("kill",    3'd0, 32'd9,        32'd9,        5'd20, 32'd81, 0, 20);
        run_op("rd0",     3'd0, 32'd6,        32'd7,        5'd0,  32'd42);
        run_op("rst",     3'd4, 32'd1000,     32'd3,        5'd21, 32'd333, 0, 0, 15);
        run_op("post_rst",3'd0, 32'd3,        32'd4,        5'd22, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
